data_mem_arb: RTL and testbench

DATA_MEM_ARB -- requirements
Module: data_mem_arb

---
 rtl/data_mem_arb_if.sv | 47 ++++
 rtl/data_mem_arb.sv | 104 ++++++++++
 tb/tb_data_mem_arb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arb_if.sv
// Requester, arbiter and memory-port signals shared by data_mem_arb and its users.
// slave = the arbiter's view, master = the requesters/memory view.
interface data_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_a_req;
  logic              i_b_req;
  logic              i_a_write;
  logic              i_b_write;
  logic              i_a_en32;
  logic              i_b_en32;
  logic [ADDR_W-1:0] i_a_address;
  logic [ADDR_W-1:0] i_b_address;
  logic [DATA_W-1:0] i_a_data_in;
  logic [DATA_W-1:0] i_b_data_in;
  logic              i_b_lock;
  logic              o_a_gnt;
  logic              o_b_gnt;
  logic              o_a_done;
  logic              o_b_done;
  logic [DATA_W-1:0] o_a_rdata;
  logic [DATA_W-1:0] o_b_rdata;
  logic              o_busy;
  logic              o_mem_read;
  logic              o_mem_write;
  logic              o_mem_en32;
  logic [ADDR_W-1:0] o_mem_address;
  logic [DATA_W-1:0] o_mem_data_in;
  logic [DATA_W-1:0] i_mem_data_out;

  modport slave (
    input  i_a_req, i_b_req, i_a_write, i_b_write, i_a_en32, i_b_en32,
    input  i_a_address, i_b_address, i_a_data_in, i_b_data_in, i_b_lock,
    input  i_mem_data_out,
    output o_a_gnt, o_b_gnt, o_a_done, o_b_done, o_a_rdata, o_b_rdata, o_busy,
    output o_mem_read, o_mem_write, o_mem_en32, o_mem_address, o_mem_data_in
  );

  modport master (
    output i_a_req, i_b_req, i_a_write, i_b_write, i_a_en32, i_b_en32,
    output i_a_address, i_b_address, i_a_data_in, i_b_data_in, i_b_lock,
    output i_mem_data_out,
    input  o_a_gnt, o_b_gnt, o_a_done, o_b_done, o_a_rdata, o_b_rdata, o_busy,
    input  o_mem_read, o_mem_write, o_mem_en32, o_mem_address, o_mem_data_in
  );
endinterface

// File: rtl/data_mem_arb.sv
// Two-requester round-robin arbiter for a single-port data memory with B-side lock.
// One access per two cycles: ISSUE drives the memory command, RESP collects load data.
module data_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  data_mem_arb_if.slave bus
);
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_b;
  logic              sel_b;
  logic              take;
  logic              cur_b;
  logic              cur_load;
  logic              win_write;
  logic              win_en32;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  function automatic logic [DATA_W-1:0] load_fmt(input logic [DATA_W-1:0] d,
                                                 input logic en32);
    logic [DATA_W-1:0] r;
    r = d;
    if (!en32) r[DATA_W-1:HALF_W] = '0;
    return r;
  endfunction

  // A tie goes to whoever was not served last, unless B is locked onto the memory.
  always_comb begin
    sel_b = bus.i_b_req;
    if (bus.i_a_req && bus.i_b_req) sel_b = last_b ? bus.i_b_lock : 1'b1;
    win_write = sel_b ? bus.i_b_write   : bus.i_a_write;
    win_en32  = sel_b ? bus.i_b_en32    : bus.i_a_en32;
    win_addr  = sel_b ? bus.i_b_address : bus.i_a_address;
    win_data  = sel_b ? bus.i_b_data_in : bus.i_a_data_in;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_a_req || bus.i_b_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = (bus.i_a_req || bus.i_b_req) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
    take = (state_nxt == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign bus.o_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b            <= 1'b1;
      cur_b             <= 1'b0;
      cur_load          <= 1'b0;
      bus.o_a_gnt       <= 1'b0;
      bus.o_b_gnt       <= 1'b0;
      bus.o_a_done      <= 1'b0;
      bus.o_b_done      <= 1'b0;
      bus.o_a_rdata     <= '0;
      bus.o_b_rdata     <= '0;
      bus.o_mem_read    <= 1'b0;
      bus.o_mem_write   <= 1'b0;
      bus.o_mem_en32    <= 1'b0;
      bus.o_mem_address <= '0;
      bus.o_mem_data_in <= '0;
    end else begin
      bus.o_a_gnt  <= take && !sel_b;
      bus.o_b_gnt  <= take && sel_b;
      bus.o_a_done <= (state == RESP) && !cur_b;
      bus.o_b_done <= (state == RESP) && cur_b;
      if (take) begin
        last_b            <= sel_b;
        cur_b             <= sel_b;
        cur_load          <= !win_write;
        bus.o_mem_read    <= !win_write;
        bus.o_mem_write   <= win_write;
        bus.o_mem_en32    <= win_en32;
        bus.o_mem_address <= win_addr;
        bus.o_mem_data_in <= win_data;
      end else begin
        bus.o_mem_read  <= 1'b0;
        bus.o_mem_write <= 1'b0;
      end
      // Address/en32 stay held through RESP, so o_mem_en32 still describes this load.
      if (state == RESP && cur_load) begin
        if (cur_b) bus.o_b_rdata <= load_fmt(bus.i_mem_data_out, bus.o_mem_en32);
        else       bus.o_a_rdata <= load_fmt(bus.i_mem_data_out, bus.o_mem_en32);
      end
    end
  end
endmodule

// File: tb/tb_data_mem_arb.sv
// Directed bench for data_mem_arb: memory model, per-requester scoreboards and grant-order log.
module tb_data_mem_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem [0:255];
  logic [255:0] written = '0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          gseq[$];
  int          gcyc[$];
  logic [31:0] exp_a_last = '0;
  logic [31:0] exp_b_last = '0;
  int          last_a_gnt = 0;
  int          last_b_gnt = 0;
  logic        prev_gnt = 1'b0;

  always #5 clk = ~clk;

  data_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  data_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h20:  return 32'hAAAA0000;
      32'h30:  return 32'hFFFF5A5A;
      default: return 32'h5EED0000 ^ (a * 32'h00010003);
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return written[a[9:2]] ? mem[a[9:2]] : init_word(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: captures commands at the rising edge, returns read data in the following cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_mem_write) begin
      mem[bus.o_mem_address[9:2]] <= bus.o_mem_en32 ? bus.o_mem_data_in :
        ((mem_word(bus.o_mem_address) & 32'hFFFF0000) | {16'h0, bus.o_mem_data_in[15:0]});
      written[bus.o_mem_address[9:2]] <= 1'b1;
    end
    if (bus.o_mem_read) bus.i_mem_data_out <= mem_word(bus.o_mem_address);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_gnt) check("resp_mem_ctrl", {30'd0, bus.o_mem_read, bus.o_mem_write}, 32'd0);
      if (bus.o_a_gnt || bus.o_b_gnt)
        check("gnt_onehot", {31'd0, bus.o_a_gnt & bus.o_b_gnt}, 32'd0);
      if (bus.o_a_done) begin
        check("a_done_latency", 32'(cyc - last_a_gnt), 32'd2);
        check("a_done_pending", {31'd0, qa.size() != 0}, 32'd1);
        if (qa.size() != 0) check("a_rdata", bus.o_a_rdata, qa.pop_front());
      end
      if (bus.o_b_done) begin
        check("b_done_latency", 32'(cyc - last_b_gnt), 32'd2);
        check("b_done_pending", {31'd0, qb.size() != 0}, 32'd1);
        if (qb.size() != 0) check("b_rdata", bus.o_b_rdata, qb.pop_front());
      end
      if (bus.o_a_gnt) begin
        last_a_gnt <= cyc;
        gseq.push_back(1'b0);
        gcyc.push_back(cyc);
      end
      if (bus.o_b_gnt) begin
        last_b_gnt <= cyc;
        gseq.push_back(1'b1);
        gcyc.push_back(cyc);
      end
      prev_gnt <= bus.o_a_gnt | bus.o_b_gnt;
    end else begin
      prev_gnt <= 1'b0;
    end
  end

  task automatic access(input bit b, input bit w, input bit e32, input logic [31:0] addr,
                        input logic [31:0] data, output int gc);
    logic [31:0] e;
    logic [31:0] raw;
    bit got;
    got = 1'b0;
    if (b) begin
      bus.i_b_req = 1'b1; bus.i_b_write = w; bus.i_b_en32 = e32;
      bus.i_b_address = addr; bus.i_b_data_in = data;
    end else begin
      bus.i_a_req = 1'b1; bus.i_a_write = w; bus.i_a_en32 = e32;
      bus.i_a_address = addr; bus.i_a_data_in = data;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = b ? bus.o_b_gnt : bus.o_a_gnt;
    end
    gc = cyc;
    if (b) bus.i_b_req = 1'b0;
    else   bus.i_a_req = 1'b0;
    check(b ? "b_gnt_seen" : "a_gnt_seen", {31'd0, got}, 32'd1);
    if (got) begin
      raw = mem_word(addr);
      if (w) e = b ? exp_b_last : exp_a_last;
      else   e = e32 ? raw : {16'h0, raw[15:0]};
      if (b) begin exp_b_last = e; qb.push_back(e); end
      else   begin exp_a_last = e; qa.push_back(e); end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check("drain", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, c0;
    bus.i_a_req = 1'b0; bus.i_b_req = 1'b0; bus.i_b_lock = 1'b0;
    bus.i_a_write = 1'b0; bus.i_b_write = 1'b0; bus.i_a_en32 = 1'b0; bus.i_b_en32 = 1'b0;
    bus.i_a_address = '0; bus.i_b_address = '0; bus.i_a_data_in = '0; bus.i_b_data_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pulses", {28'd0, bus.o_a_gnt, bus.o_b_gnt, bus.o_a_done, bus.o_b_done}, 32'd0);
    check("rst_a_rdata", bus.o_a_rdata, 32'd0);
    check("rst_b_rdata", bus.o_b_rdata, 32'd0);
    check("rst_mem_ctrl", {29'd0, bus.o_mem_read, bus.o_mem_write, bus.o_mem_en32}, 32'd0);
    check("rst_mem_addr", bus.o_mem_address, 32'd0);
    check("rst_mem_data", bus.o_mem_data_in, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // A alone: 32-bit load at 0x10
    c0 = cyc;
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, g0);
    check("a_gnt_cycle", 32'(g0 - c0), 32'd1);
    check("load_mem_ctrl", {30'd0, bus.o_mem_read, bus.o_mem_write}, 32'd2);
    check("load_mem_addr", bus.o_mem_address, 32'h10);
    check("busy_issue", {31'd0, bus.o_busy}, 32'd1);
    drain();
    check("a_rdata_32", bus.o_a_rdata, 32'hDEADBEEF);
    check("busy_idle", {31'd0, bus.o_busy}, 32'd0);

    // B: 16-bit store then back-to-back 32-bit load of the same word
    access(1'b1, 1'b1, 1'b0, 32'h20, 32'h00001234, g0);
    check("store_mem_ctrl", {30'd0, bus.o_mem_read, bus.o_mem_write}, 32'd1);
    check("store_mem_en32", {31'd0, bus.o_mem_en32}, 32'd0);
    check("store_mem_data", {16'd0, bus.o_mem_data_in[15:0]}, 32'h1234);
    check("store_mem_addr", bus.o_mem_address, 32'h20);
    access(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, g1);
    check("b_b2b_gap", 32'(g1 - g0), 32'd2);
    drain();
    check("b_rdata_merged", bus.o_b_rdata, 32'hAAAA1234);

    // A: 16-bit load, upper half must be zero
    access(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, g0);
    drain();
    check("a_rdata_16", bus.o_a_rdata, 32'h00005A5A);
    check("b_rdata_hold", bus.o_b_rdata, 32'hAAAA1234);

    // Both requesting continuously; A was served last so B leads
    gseq.delete(); gcyc.delete();
    fork
      begin
        int ga;
        for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i * 8), 32'h0, ga);
      end
      begin
        int gb;
        for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 1'b1, 32'h104 + 32'(i * 8), 32'h0, gb);
      end
    join
    drain();
    check("rr_count", 32'(gseq.size()), 32'd8);
    for (int i = 0; i < gseq.size(); i++) begin
      check("rr_order", 32'(gseq[i]), 32'(i % 2 == 0));
      if (i > 0) check("rr_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
    end

    // B locked for two stores while A waits
    gseq.delete(); gcyc.delete();
    fork
      begin
        int ga;
        access(1'b0, 1'b0, 1'b1, 32'h140, 32'h0, ga);
      end
      begin
        int gb;
        bus.i_b_lock = 1'b1;
        access(1'b1, 1'b1, 1'b1, 32'h180, 32'h0BADF00D, gb);
        access(1'b1, 1'b1, 1'b1, 32'h184, 32'h600DCAFE, gb);
      end
    join
    drain();
    bus.i_b_lock = 1'b0;
    check("lock_count", 32'(gseq.size()), 32'd3);
    check("lock_first_b", 32'(gseq[0]), 32'd1);
    check("lock_second_b", 32'(gseq[1]), 32'd1);
    check("lock_then_a", 32'(gseq[2]), 32'd0);
    check("lock_gap1", 32'(gcyc[1] - gcyc[0]), 32'd2);
    check("lock_gap2", 32'(gcyc[2] - gcyc[1]), 32'd2);
    check("lock_store0", mem_word(32'h180), 32'h0BADF00D);
    check("lock_store1", mem_word(32'h184), 32'h600DCAFE);

    // Reset during the ISSUE cycle of a store
    access(1'b1, 1'b1, 1'b1, 32'h60, 32'h00000055, g0);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_write", {31'd0, bus.o_mem_write}, 32'd0);
    check("abort_busy", {31'd0, bus.o_busy}, 32'd0);
    check("abort_gnt", {30'd0, bus.o_a_gnt, bus.o_b_gnt}, 32'd0);
    qa.delete(); qb.delete();
    exp_a_last = '0; exp_b_last = '0;
    repeat (2) @(negedge clk);
    check("abort_mem_unchanged", {31'd0, written[24]}, 32'd0);
    check("abort_b_rdata", bus.o_b_rdata, 32'd0);
    rst = 1'b0;

    // First tie after reset goes to A, honoured at the next edge
    c0 = cyc;
    gseq.delete(); gcyc.delete();
    fork
      begin
        int ga;
        access(1'b0, 1'b0, 1'b1, 32'h1C0, 32'h0, ga);
      end
      begin
        int gb;
        access(1'b1, 1'b0, 1'b1, 32'h1C4, 32'h0, gb);
      end
    join
    drain();
    check("post_rst_count", 32'(gseq.size()), 32'd2);
    check("post_rst_a_first", 32'(gseq[0]), 32'd0);
    check("post_rst_a_cycle", 32'(gcyc[0] - c0), 32'd1);
    check("post_rst_b_second", 32'(gseq[1]), 32'd1);
    check("post_rst_no_abort_done", {31'd0, written[24]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
